// File: rtl/neuro_pkg.sv
// Shared types and helpers for the neuron array controller.
//   ctrl_state_t : top-level sequencing states
//   cfg_field_t  : per-neuron config field order as presented on the word port
//   clog2_min1() : ceil(log2(value)), never less than 1
package neuro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CFG   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        F_VMEM     = 2'd0,
        F_MU       = 2'd1,
        F_NEURONI  = 2'd2,
        F_Q        = 2'd3
    } cfg_field_t;

    localparam int ACTIVE_BITS_W = 4;

    // Smallest b >= 1 with 2**b >= value.
    function automatic int clog2_min1(input int unsigned value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << (i - 1)) < value) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/neuro_state_readout_ser.sv
// state_readout_ser: owns the per-neuron spin state vector.
//   - Toggles state[spike_id] on a valid non-zero spike while running,
//     ignoring ids at or beyond the active count.
//   - While draining, presents the vector as RD_WIDTH-bit words, lowest
//     neuron first; bits at or beyond the active count read as 0.
// Ports:
//   i_clk, i_reset       clock, async active-high reset (state -> all ones)
//   i_clear              soft restart: rewinds the word pointer, state kept
//   i_run, i_drain       phase qualifiers from the controller FSM
//   i_active_cnt         number of active neurons (1..NUM_NEURON)
//   i_spike_*            spike event from the network
//   o_out_valid/data/last, i_out_ready   readout stream
//   o_last_taken         combinational: final word handshaken this cycle
//   o_read_done          one-cycle pulse the cycle after the final handshake
module state_readout_ser
    import neuro_pkg::*;
#(
    parameter int NUM_NEURON = 256,
    parameter int ID_WIDTH   = 8,
    parameter int TEN_WIDTH  = 2,
    parameter int RD_WIDTH   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_run,
    input  logic                 i_drain,
    input  logic [ID_WIDTH:0]    i_active_cnt,
    input  logic                 i_spike_valid,
    input  logic [ID_WIDTH-1:0]  i_spike_id,
    input  logic [TEN_WIDTH-1:0] i_spike_val,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [RD_WIDTH-1:0]  o_out_data,
    output logic                 o_out_last,
    output logic                 o_last_taken,
    output logic                 o_read_done
);

    localparam int NUM_WORDS  = (NUM_NEURON + RD_WIDTH - 1) / RD_WIDTH;
    localparam int WORD_W     = clog2_min1(NUM_WORDS);
    // Word table is sized to a power of two so the pointer indexes it exactly.
    localparam int WORD_SLOTS = 1 << WORD_W;
    localparam int PAD        = WORD_SLOTS * RD_WIDTH;

    logic [NUM_NEURON-1:0] r_state;
    logic [WORD_W-1:0]     r_word;
    logic                  r_read_done;

    logic [PAD-1:0]        w_padded;
    logic [PAD-1:0]        w_masked;
    logic [RD_WIDTH-1:0]   w_words [WORD_SLOTS];
    logic [WORD_W-1:0]     w_last_word;
    logic                  w_hit;
    logic                  w_fire;

    always_comb begin
        w_padded = '0;
        w_padded[NUM_NEURON-1:0] = r_state;
    end

    genvar g;
    for (g = 0; g < PAD; g++) begin : g_mask
        assign w_masked[g] = w_padded[g] & (32'(g) < 32'(i_active_cnt));
    end

    for (g = 0; g < WORD_SLOTS; g++) begin : g_word
        assign w_words[g] = w_masked[g*RD_WIDTH +: RD_WIDTH];
    end

    // Active count is never 0 (clamped upstream), so the subtraction is safe.
    assign w_last_word = WORD_W'((32'(i_active_cnt) - 32'd1) / RD_WIDTH);

    assign w_hit = i_run && i_spike_valid && (i_spike_val != '0)
                   && (32'(i_spike_id) < 32'(i_active_cnt));

    assign o_out_valid  = i_drain;
    assign o_out_data   = i_drain ? w_words[r_word] : '0;
    assign o_out_last   = i_drain && (r_word == w_last_word);
    assign w_fire       = i_drain && i_out_ready && !i_clear;
    assign o_last_taken = w_fire && o_out_last;
    assign o_read_done  = r_read_done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= '1;
            r_word      <= '0;
            r_read_done <= 1'b0;
        end else begin
            r_read_done <= o_last_taken;
            if (i_clear) begin
                r_word <= '0;
            end else if (w_fire) begin
                r_word <= o_out_last ? '0 : r_word + WORD_W'(1);
            end
            for (int i = 0; i < NUM_NEURON; i++) begin
                if (w_hit && (i_spike_id == ID_WIDTH'(i))) begin
                    r_state[i] <= ~r_state[i];
                end
            end
        end
    end

endmodule

// File: rtl/neuro_array_ctrl.sv
// neuro_array_ctrl: sequencing controller for a NUM_NEURON neuron array.
//   Loads the active neuron count, streams per-neuron config words to the
//   array, gates the run phase and hands state readout to state_readout_ser.
// Ports:
//   i_clk, i_reset                      clock, async active-high reset
//   i_restart                           sync return to IDLE (state, count kept)
//   i_in_valid/o_in_ready/i_in_data     input word port
//   o_cfg_we/neuron/field/data, i_cfg_ack   config write, held until ack
//   o_run_en                            array / network enable
//   i_spike_valid/id/val                spike events
//   i_rd_req                            request a state readout
//   o_out_valid/data/last, i_out_ready  readout stream
//   o_read_done                         pulse after final readout word
//   o_active_cnt, o_active_bits         active count and its ceil(log2)
//
// state | meaning
// IDLE  | accept count words; BEGIN_WORD starts configuration
// CFG   | one config write per accepted word, waits for cfg_ack
// RUN   | array enabled, spikes toggle neuron states
// DRAIN | array halted, state vector streamed out
module neuro_array_ctrl
    import neuro_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TEN_WIDTH  = 2,
    parameter int NUM_NEURON = 256,
    parameter int ID_WIDTH   = 8,
    parameter int CFG_FIELDS = 4,
    parameter int RD_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] BEGIN_WORD = '1,
    localparam int FIELD_W   = clog2_min1(CFG_FIELDS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_restart,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [DATA_WIDTH-1:0]    i_in_data,
    output logic                     o_cfg_we,
    output logic [ID_WIDTH-1:0]      o_cfg_neuron,
    output logic [FIELD_W-1:0]       o_cfg_field,
    output logic [DATA_WIDTH-1:0]    o_cfg_data,
    input  logic                     i_cfg_ack,
    output logic                     o_run_en,
    input  logic                     i_spike_valid,
    input  logic [ID_WIDTH-1:0]      i_spike_id,
    input  logic [TEN_WIDTH-1:0]     i_spike_val,
    input  logic                     i_rd_req,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [RD_WIDTH-1:0]      o_out_data,
    output logic                     o_out_last,
    output logic                     o_read_done,
    output logic [ID_WIDTH:0]        o_active_cnt,
    output logic [ACTIVE_BITS_W-1:0] o_active_bits
);

    localparam logic [FIELD_W-1:0]       LAST_FIELD = FIELD_W'(CFG_FIELDS - 1);
    localparam logic [ID_WIDTH:0]        FULL_CNT   = (ID_WIDTH + 1)'(NUM_NEURON);
    localparam logic [ACTIVE_BITS_W-1:0] FULL_BITS  = ACTIVE_BITS_W'(clog2_min1(NUM_NEURON));

    ctrl_state_t              r_state;
    ctrl_state_t              w_next_state;
    logic                     r_cfg_we;
    logic [DATA_WIDTH-1:0]    r_cfg_data;
    logic [ID_WIDTH-1:0]      r_neuron;
    logic [FIELD_W-1:0]       r_field;
    logic [ID_WIDTH:0]        r_active_cnt;
    logic [ACTIVE_BITS_W-1:0] r_active_bits;

    logic                     w_in_fire;
    logic                     w_is_begin;
    logic                     w_cfg_done;
    logic                     w_cfg_last;
    logic [ID_WIDTH:0]        w_clamped_cnt;
    logic                     w_ser_run;
    logic                     w_ser_drain;
    logic                     w_last_taken;

    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_is_begin = (i_in_data == BEGIN_WORD);
    assign w_cfg_done = r_cfg_we && i_cfg_ack;
    assign w_cfg_last = (r_field == LAST_FIELD)
                        && ((ID_WIDTH + 1)'(r_neuron) == r_active_cnt - (ID_WIDTH + 1)'(1));

    // A count of 0 or anything above the physical array means "use all of it".
    always_comb begin
        w_clamped_cnt = (ID_WIDTH + 1)'(i_in_data);
        if ((i_in_data == '0) || (32'(i_in_data) > NUM_NEURON)) begin
            w_clamped_cnt = FULL_CNT;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        o_run_en     = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid && w_is_begin) begin
                    w_next_state = CFG;
                end
            end
            CFG: begin
                // Ready only between writes: the pending write must be acked first.
                o_in_ready = !r_cfg_we;
                if (w_cfg_done && w_cfg_last) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                o_run_en = 1'b1;
                if (i_rd_req) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_taken) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (i_restart) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cfg_we      <= 1'b0;
            r_cfg_data    <= '0;
            r_neuron      <= '0;
            r_field       <= '0;
            r_active_cnt  <= FULL_CNT;
            r_active_bits <= FULL_BITS;
        end else begin
            r_active_bits <= ACTIVE_BITS_W'(clog2_min1(32'(r_active_cnt)));
            if (i_restart) begin
                r_cfg_we <= 1'b0;
                r_neuron <= '0;
                r_field  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_in_fire) begin
                            if (w_is_begin) begin
                                r_neuron <= '0;
                                r_field  <= '0;
                            end else begin
                                r_active_cnt <= w_clamped_cnt;
                            end
                        end
                    end
                    CFG: begin
                        if (w_cfg_done) begin
                            r_cfg_we <= 1'b0;
                            if (r_field == LAST_FIELD) begin
                                r_field  <= '0;
                                r_neuron <= w_cfg_last ? '0 : r_neuron + ID_WIDTH'(1);
                            end else begin
                                r_field <= r_field + FIELD_W'(1);
                            end
                        end else if (w_in_fire) begin
                            r_cfg_we   <= 1'b1;
                            r_cfg_data <= i_in_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_cfg_we      = r_cfg_we;
    assign o_cfg_neuron  = r_neuron;
    assign o_cfg_field   = r_field;
    assign o_cfg_data    = r_cfg_data;
    assign o_active_cnt  = r_active_cnt;
    assign o_active_bits = r_active_bits;

    assign w_ser_run   = (r_state == RUN) && !i_restart;
    assign w_ser_drain = (r_state == DRAIN);

    state_readout_ser #(
        .NUM_NEURON (NUM_NEURON),
        .ID_WIDTH   (ID_WIDTH),
        .TEN_WIDTH  (TEN_WIDTH),
        .RD_WIDTH   (RD_WIDTH)
    ) u_state_readout_ser (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_clear       (i_restart),
        .i_run         (w_ser_run),
        .i_drain       (w_ser_drain),
        .i_active_cnt  (r_active_cnt),
        .i_spike_valid (i_spike_valid),
        .i_spike_id    (i_spike_id),
        .i_spike_val   (i_spike_val),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_out_last    (o_out_last),
        .o_last_taken  (w_last_taken),
        .o_read_done   (o_read_done)
    );

endmodule
